pcs_receive: RTL and testbench
==============================

// Module: pcs_receive
// PURPOSE
//  1000BASE-X PCS receive path (802.3 Cl.36 subset). Takes aligned 10-bit code-groups
//  from the synchronizer (SUDI), decodes 8B/10B and frames packets into GMII-style
//  RX_DV/RXD. Sits between the sync block and the MAC-side GMII receive interface.
// PARAMETERS
//  none (code-group constants come from the shared package)
// PORTS
//  clk          in   1   rising-edge clock; one code-group per cycle
//  reset        in   1   asynchronous, active-low reset
//  sync_status  in   1   1 = synchronizer locked (OK), 0 = FAIL
//  SUDI         in   11  [10]=rx_even, [9:0]=code-group abcdei_fghj, a = bit 9, j = bit 0
//  RX_DV        out  1   GMII receive data valid
//  RXD          out  8   GMII receive data {H,G,F,E,D,C,B,A}
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low. reset=0 -> state LINK_FAILED,
//    RX_DV=0, RXD=8'h00 immediately.
//  - Outputs registered: RX_DV/RXD reflect the SUDI sampled on the previous rising edge
//    (latency 1 clk).
//  - Decode: 5b/6b on SUDI[9:4] -> EDCBA, 3b/4b on SUDI[3:0] -> HGF; both disparity
//    columns accepted, no running-disparity checking. Specials recognised (either RD):
//    K28.5 0011111010/1100000101, /S/ K27.7 1101101000/0010010111,
//    /T/ K29.7 1011101000/0100010111, /R/ K23.7 1110101000/0001010111.
//    Any group not in the D table or special set = INVALID.
//  - sync_status=0 in any state -> LINK_FAILED next edge (overrides all below).
//  - LINK_FAILED: RX_DV=0, RXD=00. sync_status=1 -> WAIT_FOR_K.
//  - WAIT_FOR_K: RX_DV=0. K28.5 with rx_even=1 -> RX_K; otherwise stay.
//  - RX_K: RX_DV=0. Any valid D group -> IDLE_D; else -> WAIT_FOR_K.
//  - IDLE_D: RX_DV=0. K28.5 -> RX_K; /S/ -> START_OF_PACKET; else -> WAIT_FOR_K.
//  - START_OF_PACKET: RX_DV=1, RXD=8'h55 (the /S/ is replaced by a preamble byte).
//    Next: D -> RECEIVE; otherwise handled as in RECEIVE.
//  - RECEIVE: D group -> RX_DV=1, RXD=decoded byte, stay.
//    /T/ -> TRI_RRI, RX_DV=0, RXD=00.
//    K28.5 (early end) -> RX_K, RX_DV=0.
//    INVALID or /S//R/ -> WAIT_FOR_K, RX_DV=0, RXD=00.
//  - TRI_RRI: RX_DV=0. /R/ -> stay; K28.5 -> RX_K; other -> WAIT_FOR_K.
//  - Whenever RX_DV=0, RXD is driven 8'h00.
//  - Reset or sync loss mid-packet: RX_DV drops next edge (async for reset), no flush.
// STRUCTURE
//  - Package pcs_rx_pkg: state enum (LINK_FAILED, WAIT_FOR_K, RX_K, IDLE_D,
//    START_OF_PACKET, RECEIVE, TRI_RRI), K28.5/K27.7/K29.7/K23.7 constants (both RD),
//    PREAMBLE=8'h55.
//  - Sub-module pcs_rx_decode (combinational): code[9:0] -> data[7:0],
//    is_data, is_comma, is_s, is_t, is_r, invalid.
//  - Top: state register and output registers.
// TESTING
//  1 reset=0 with random SUDI -> RX_DV=0, RXD=00; release; sync_status=0 -> stays
//    LINK_FAILED, outputs 0.
//  2 sync=1, SUDI={1,K28.5 0011111010}, {0,D16.2 0110110101} repeated ->
//    reaches IDLE_D, RX_DV stays 0.
//  3 Idle, then /S/ 1101101000, D21.5 1010101010, D0.0 1001110100, /T/, /R/, K28.5
//    -> RX_DV=1 with RXD 55, B5, 00, then RX_DV=0.
//  4 Mid-packet SUDI=1111111111 (invalid) -> next cycle RX_DV=0, RXD=00;
//    later K28.5 (even) -> resync via RX_K.
//  5 Mid-packet sync_status 1->0 -> RX_DV=0 next edge; mid-packet reset=0 ->
//    RX_DV=0 immediately.
//  6 Same packet with RD+ columns of specials/data -> identical RXD bytes.

Source files
------------

// File: rtl/pcs_rx_pkg.sv
// Shared types and code-group constants for the 1000BASE-X PCS receive path.
// Specials are listed in both running-disparity columns.
package pcs_rx_pkg;

    typedef enum logic [2:0] {
        LINK_FAILED,
        WAIT_FOR_K,
        RX_K,
        IDLE_D,
        START_OF_PACKET,
        RECEIVE,
        TRI_RRI
    } rx_state_t;

    localparam logic [9:0] K28_5_N = 10'b0011111010;
    localparam logic [9:0] K28_5_P = 10'b1100000101;
    localparam logic [9:0] K27_7_N = 10'b1101101000;
    localparam logic [9:0] K27_7_P = 10'b0010010111;
    localparam logic [9:0] K29_7_N = 10'b1011101000;
    localparam logic [9:0] K29_7_P = 10'b0100010111;
    localparam logic [9:0] K23_7_N = 10'b1110101000;
    localparam logic [9:0] K23_7_P = 10'b0001010111;

    localparam logic [7:0] PREAMBLE = 8'h55;

endpackage

// File: rtl/pcs_rx_decode.sv
// Combinational 8B/10B decoder: classifies one code-group and
// returns the data byte; disparity is not tracked.
module pcs_rx_decode
    import pcs_rx_pkg::*;
(
    input  logic [9:0] i_code,
    output logic [7:0] o_data,
    output logic       o_is_data,
    output logic       o_is_comma,
    output logic       o_is_s,
    output logic       o_is_t,
    output logic       o_is_r,
    output logic       o_invalid
);

    logic [4:0] w_edcba;
    logic [2:0] w_hgf;
    logic       w_v6;
    logic       w_v4;
    logic       w_a7_ok;
    logic       w_special;

    always_comb begin
        w_v6    = 1'b1;
        w_edcba = 5'd0;
        case (i_code[9:4])
            6'b100111, 6'b011000: w_edcba = 5'd0;
            6'b011101, 6'b100010: w_edcba = 5'd1;
            6'b101101, 6'b010010: w_edcba = 5'd2;
            6'b110001:            w_edcba = 5'd3;
            6'b110101, 6'b001010: w_edcba = 5'd4;
            6'b101001:            w_edcba = 5'd5;
            6'b011001:            w_edcba = 5'd6;
            6'b111000, 6'b000111: w_edcba = 5'd7;
            6'b111001, 6'b000110: w_edcba = 5'd8;
            6'b100101:            w_edcba = 5'd9;
            6'b010101:            w_edcba = 5'd10;
            6'b110100:            w_edcba = 5'd11;
            6'b001101:            w_edcba = 5'd12;
            6'b101100:            w_edcba = 5'd13;
            6'b011100:            w_edcba = 5'd14;
            6'b010111, 6'b101000: w_edcba = 5'd15;
            6'b011011, 6'b100100: w_edcba = 5'd16;
            6'b100011:            w_edcba = 5'd17;
            6'b010011:            w_edcba = 5'd18;
            6'b110010:            w_edcba = 5'd19;
            6'b001011:            w_edcba = 5'd20;
            6'b101010:            w_edcba = 5'd21;
            6'b011010:            w_edcba = 5'd22;
            6'b111010, 6'b000101: w_edcba = 5'd23;
            6'b110011, 6'b001100: w_edcba = 5'd24;
            6'b100110:            w_edcba = 5'd25;
            6'b010110:            w_edcba = 5'd26;
            6'b110110, 6'b001001: w_edcba = 5'd27;
            6'b001110:            w_edcba = 5'd28;
            6'b101110, 6'b010001: w_edcba = 5'd29;
            6'b011110, 6'b100001: w_edcba = 5'd30;
            6'b101011, 6'b010100: w_edcba = 5'd31;
            default:              w_v6    = 1'b0;
        endcase
    end

    always_comb begin
        w_v4  = 1'b1;
        w_hgf = 3'd0;
        case (i_code[3:0])
            4'b1011, 4'b0100: w_hgf = 3'd0;
            4'b1001:          w_hgf = 3'd1;
            4'b0101:          w_hgf = 3'd2;
            4'b1100, 4'b0011: w_hgf = 3'd3;
            4'b1101, 4'b0010: w_hgf = 3'd4;
            4'b1010:          w_hgf = 3'd5;
            4'b0110:          w_hgf = 3'd6;
            4'b1110, 4'b0001,
            4'b0111, 4'b1000: w_hgf = 3'd7;
            default:          w_v4  = 1'b0;
        endcase
    end

    // Alternate D.x.7 encodings exist only for these x values
    always_comb begin
        w_a7_ok = 1'b1;
        if (i_code[3:0] == 4'b0111)
            w_a7_ok = (w_edcba == 5'd17) || (w_edcba == 5'd18)
                   || (w_edcba == 5'd20);
        else if (i_code[3:0] == 4'b1000)
            w_a7_ok = (w_edcba == 5'd11) || (w_edcba == 5'd13)
                   || (w_edcba == 5'd14);
    end

    assign o_is_comma = (i_code == K28_5_N) || (i_code == K28_5_P);
    assign o_is_s     = (i_code == K27_7_N) || (i_code == K27_7_P);
    assign o_is_t     = (i_code == K29_7_N) || (i_code == K29_7_P);
    assign o_is_r     = (i_code == K23_7_N) || (i_code == K23_7_P);

    assign w_special = o_is_comma | o_is_s | o_is_t | o_is_r;
    assign o_is_data = w_v6 & w_v4 & w_a7_ok & ~w_special;
    assign o_invalid = ~o_is_data & ~w_special;
    assign o_data    = {w_hgf, w_edcba};

endmodule

// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive: decodes SUDI code-groups and frames
// packets onto registered GMII RX_DV/RXD.
module pcs_receive
    import pcs_rx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sync_status,
    input  logic [10:0] SUDI,
    output logic        RX_DV,
    output logic [7:0]  RXD
);

    rx_state_t  r_state;
    logic       r_dv;
    logic [7:0] r_rxd;

    logic [7:0] w_byte;
    logic       w_data;
    logic       w_comma;
    logic       w_s;
    logic       w_t;
    logic       w_r;
    logic       w_invalid;
    logic       w_even;

    assign w_even = SUDI[10];

    pcs_rx_decode u_decode (
        .i_code     (SUDI[9:0]),
        .o_data     (w_byte),
        .o_is_data  (w_data),
        .o_is_comma (w_comma),
        .o_is_s     (w_s),
        .o_is_t     (w_t),
        .o_is_r     (w_r),
        .o_invalid  (w_invalid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= LINK_FAILED;
            r_dv    <= 1'b0;
            r_rxd   <= 8'h00;
        end else begin
            r_dv  <= 1'b0;
            r_rxd <= 8'h00;
            if (!sync_status) begin
                r_state <= LINK_FAILED;
            end else begin
                unique case (r_state)
                    LINK_FAILED: r_state <= WAIT_FOR_K;
                    WAIT_FOR_K: begin
                        if (w_comma && w_even)
                            r_state <= RX_K;
                    end
                    RX_K: r_state <= w_data ? IDLE_D : WAIT_FOR_K;
                    IDLE_D: begin
                        if (w_comma) begin
                            r_state <= RX_K;
                        end else if (w_s) begin
                            r_state <= START_OF_PACKET;
                            r_dv    <= 1'b1;
                            r_rxd   <= PREAMBLE;
                        end else begin
                            r_state <= WAIT_FOR_K;
                        end
                    end
                    START_OF_PACKET, RECEIVE: begin
                        if (w_data) begin
                            r_state <= RECEIVE;
                            r_dv    <= 1'b1;
                            r_rxd   <= w_byte;
                        end else if (w_t) begin
                            r_state <= TRI_RRI;
                        end else if (w_comma) begin
                            r_state <= RX_K;
                        end else begin
                            r_state <= WAIT_FOR_K;
                        end
                    end
                    TRI_RRI: begin
                        if (w_comma)
                            r_state <= RX_K;
                        else if (!w_r)
                            r_state <= WAIT_FOR_K;
                    end
                    default: r_state <= LINK_FAILED;
                endcase
            end
        end
    end

    assign RX_DV = r_dv;
    assign RXD   = r_rxd;

endmodule

// File: tb/tb_pcs_receive.sv
// Directed vector bench for pcs_receive: table of per-cycle
// inputs and expected GMII outputs plus an async-reset sequence.
module tb_pcs_receive;

    logic        clk;
    logic        reset;
    logic        sync_status;
    logic [10:0] SUDI;
    logic        RX_DV;
    logic [7:0]  RXD;

    int n_pass;
    int n_total;

    localparam logic [9:0] K28N = 10'b0011111010;
    localparam logic [9:0] K28P = 10'b1100000101;
    localparam logic [9:0] SN   = 10'b1101101000;
    localparam logic [9:0] SP   = 10'b0010010111;
    localparam logic [9:0] TN   = 10'b1011101000;
    localparam logic [9:0] TP   = 10'b0100010111;
    localparam logic [9:0] RN   = 10'b1110101000;
    localparam logic [9:0] RP   = 10'b0001010111;
    localparam logic [9:0] D162 = 10'b0110110101;
    localparam logic [9:0] D16P = 10'b1001000101;
    localparam logic [9:0] D215 = 10'b1010101010;
    localparam logic [9:0] D00N = 10'b1001110100;
    localparam logic [9:0] D00P = 10'b0110001011;
    localparam logic [9:0] BAD  = 10'b1111111111;

    typedef struct packed {
        logic       rst_n;
        logic       sync;
        logic       rnd;
        logic       even;
        logic [9:0] code;
        logic       dv;
        logic [7:0] rxd;
    } vec_t;

    vec_t vq[$];

    pcs_receive dut (
        .clk         (clk),
        .reset       (reset),
        .sync_status (sync_status),
        .SUDI        (SUDI),
        .RX_DV       (RX_DV),
        .RXD         (RXD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic s,
                       input logic e, input logic [9:0] c,
                       input logic dv, input logic [7:0] d);
        vec_t v;
        v.rst_n = r;
        v.sync  = s;
        v.rnd   = 1'b0;
        v.even  = e;
        v.code  = c;
        v.dv    = dv;
        v.rxd   = d;
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input logic dv,
                         input logic [7:0] d);
        n_total++;
        if (RX_DV === dv && RXD === d) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got dv=%b rxd=%h, want dv=%b rxd=%h",
                     nm, RX_DV, RXD, dv, d);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        reset       = v.rst_n;
        sync_status = v.sync;
        if (v.rnd)
            SUDI = 11'($urandom);
        else
            SUDI = {v.even, v.code};
        @(posedge clk);
        #1;
        check($sformatf("vec%0d", idx), v.dv, v.rxd);
    endtask

    initial begin
        vec_t rv;
        n_pass      = 0;
        n_total     = 0;
        reset       = 1'b0;
        sync_status = 1'b0;
        SUDI        = '0;

        // reset with random SUDI, then sync down
        for (int i = 0; i < 3; i++) begin
            rv = '0;
            rv.sync = 1'b1;
            rv.rnd  = 1'b1;
            vq.push_back(rv);
        end
        add(1, 0, 1, K28N, 0, 8'h00);
        add(1, 0, 1, K28N, 0, 8'h00);
        // acquire idle
        add(1, 1, 1, K28N, 0, 8'h00);
        add(1, 1, 1, K28N, 0, 8'h00);
        add(1, 1, 0, D162, 0, 8'h00);
        add(1, 1, 1, K28N, 0, 8'h00);
        add(1, 1, 0, D162, 0, 8'h00);
        // packet, RD- specials
        add(1, 1, 1, SN,   1, 8'h55);
        add(1, 1, 0, D215, 1, 8'hB5);
        add(1, 1, 1, D00N, 1, 8'h00);
        add(1, 1, 0, TN,   0, 8'h00);
        add(1, 1, 1, RN,   0, 8'h00);
        add(1, 1, 0, RN,   0, 8'h00);
        add(1, 1, 1, K28N, 0, 8'h00);
        add(1, 1, 0, D162, 0, 8'h00);
        // same packet, RD+ columns
        add(1, 1, 1, SP,   1, 8'h55);
        add(1, 1, 0, D215, 1, 8'hB5);
        add(1, 1, 1, D00P, 1, 8'h00);
        add(1, 1, 0, TP,   0, 8'h00);
        add(1, 1, 1, RP,   0, 8'h00);
        add(1, 1, 0, K28P, 0, 8'h00);
        add(1, 1, 1, D16P, 0, 8'h00);
        // invalid mid-packet, then resync
        add(1, 1, 0, SN,   1, 8'h55);
        add(1, 1, 1, D215, 1, 8'hB5);
        add(1, 1, 0, BAD,  0, 8'h00);
        add(1, 1, 1, SN,   0, 8'h00);
        add(1, 1, 0, D215, 0, 8'h00);
        add(1, 1, 1, K28N, 0, 8'h00);
        add(1, 1, 0, D162, 0, 8'h00);
        // early end on K28.5
        add(1, 1, 1, SN,   1, 8'h55);
        add(1, 1, 0, D00N, 1, 8'h00);
        add(1, 1, 1, K28N, 0, 8'h00);
        add(1, 1, 0, D162, 0, 8'h00);
        // odd-position comma must not leave WAIT_FOR_K
        add(1, 1, 1, D215, 0, 8'h00);
        add(1, 1, 0, K28N, 0, 8'h00);
        add(1, 1, 1, D162, 0, 8'h00);
        add(1, 1, 1, SN,   0, 8'h00);
        add(1, 1, 1, K28N, 0, 8'h00);
        add(1, 1, 0, D162, 0, 8'h00);
        // sync loss mid-packet and recovery
        add(1, 1, 1, SN,   1, 8'h55);
        add(1, 1, 0, D215, 1, 8'hB5);
        add(1, 0, 1, D00N, 0, 8'h00);
        add(1, 1, 1, K28N, 0, 8'h00);
        add(1, 1, 1, K28N, 0, 8'h00);
        add(1, 1, 0, D162, 0, 8'h00);
        add(1, 1, 1, SN,   1, 8'h55);
        add(1, 1, 0, D215, 1, 8'hB5);

        foreach (vq[i]) apply(vq[i], i);

        // asynchronous reset in the middle of a packet
        @(negedge clk);
        check("pre_reset", 1'b1, 8'hB5);
        reset = 1'b0;
        #1;
        check("async_reset", 1'b0, 8'h00);
        @(posedge clk);
        #1;
        check("reset_hold", 1'b0, 8'h00);

        rv = '0;
        rv.rst_n = 1'b1;
        rv.sync  = 1'b1;
        rv.even  = 1'b1;
        rv.code  = K28N;
        apply(rv, 100);
        apply(rv, 101);
        rv.even = 1'b0;
        rv.code = D162;
        apply(rv, 102);
        rv.code = SN;
        rv.dv   = 1'b1;
        rv.rxd  = 8'h55;
        apply(rv, 103);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
